// File: rtl/br_checkpoint_ctrl_if.sv
// br_checkpoint_ctrl_if
//   Rename/commit side bundle for the branch-checkpoint controller.
//   master : rename + commit logic (drives requests, retires, recovers)
//   slave  : br_checkpoint_ctrl (grants indices, snapshot strobe, restore window)
//   Signals:
//     stall        rename stalled downstream, no allocation this cycle
//     alloc_req    per-slot valid-branch flags of the rename group
//     alloc_ready  group may allocate this cycle
//     alloc_idx    granted checkpoint index per slot, packed slot-major
//     check        mapping-table snapshot strobe
//     check_flag   which slots snapshot
//     retire_br    per-commit-slot branch flags (free head in order)
//     recover      mispredict; keep slots up to and including recover_idx
//     recover_idx  checkpoint of the mispredicted branch
//     recovering   restore window active
interface br_checkpoint_ctrl_if #(
   parameter int unsigned CP_IDX_W     = 3,
   parameter int unsigned RENAME_WIDTH = 2,
   parameter int unsigned COMMIT_WIDTH = 2
);
   logic                             stall;
   logic [RENAME_WIDTH-1:0]          alloc_req;
   logic                             alloc_ready;
   logic [RENAME_WIDTH*CP_IDX_W-1:0] alloc_idx;
   logic                             check;
   logic [RENAME_WIDTH-1:0]          check_flag;
   logic [COMMIT_WIDTH-1:0]          retire_br;
   logic                             recover;
   logic [CP_IDX_W-1:0]              recover_idx;
   logic                             recovering;

   modport master (
      output stall, alloc_req, retire_br, recover, recover_idx,
      input  alloc_ready, alloc_idx, check, check_flag, recovering
   );

   modport slave (
      input  stall, alloc_req, retire_br, recover, recover_idx,
      output alloc_ready, alloc_idx, check, check_flag, recovering
   );
endinterface

// File: rtl/br_checkpoint_ctrl.sv
// br_checkpoint_ctrl
//   Circular queue of RAT branch-checkpoint slots (head = oldest live slot).
//   Grants indices to a rename group all-or-nothing, frees slots in order at
//   commit, and on mispredict drops younger slots then blocks rename for a
//   fixed restore window while the mapping table rolls back.
//   Ports:
//     clock    core clock, rising edge
//     reset    asynchronous, active-low
//     cp_if    rename/commit bundle (slave side)
//     cp_head  oldest live slot
//     cp_size  live slot count, 0..CP_SIZE
//     err      sticky protocol error (over-retire, recover to a dead slot)
module br_checkpoint_ctrl #(
   parameter int unsigned CP_SIZE      = 8,
   parameter int unsigned CP_IDX_W     = 3,
   parameter int unsigned RENAME_WIDTH = 2,
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned RESTORE_CYC  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   br_checkpoint_ctrl_if.slave   cp_if,
   output logic [CP_IDX_W-1:0]   cp_head,
   output logic [CP_IDX_W:0]     cp_size,
   output logic                  err
);

   localparam int unsigned SZ_W  = CP_IDX_W + 1;
   localparam int unsigned SUM_W = CP_IDX_W + 2;
   localparam int unsigned CNT_W = (RESTORE_CYC > 1) ? $clog2(RESTORE_CYC) : 1;

   typedef enum logic {
      RUN     = 1'b0,
      RESTORE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CP_IDX_W-1:0] head_q, head_d;
   logic [SZ_W-1:0]     size_q, size_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;

   logic [SZ_W-1:0]     n_ret;
   logic [SUM_W-1:0]    n_req;
   logic [CP_IDX_W-1:0] head_r;
   logic [SZ_W-1:0]     size_r;
   logic                ret_err;
   logic [CP_IDX_W-1:0] rec_dist;
   logic                rec_live;
   logic [SUM_W-1:0]    size_sum;
   logic                ready;
   logic                fire;
   logic [CP_IDX_W-1:0] alloc_base;
   logic [CP_IDX_W-1:0] alloc_off;
   logic [RENAME_WIDTH*CP_IDX_W-1:0] idx_vec;

   // Retire stage; recover and allocate both see the post-retire queue.
   always_comb begin
      n_ret = '0;
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
         n_ret = n_ret + SZ_W'(cp_if.retire_br[j]);
      end
      ret_err = (n_ret > size_q);
      if (ret_err) begin
         // Over-retire drains the queue; head lands just past the last live slot.
         head_r = head_q + size_q[CP_IDX_W-1:0];
         size_r = '0;
      end else begin
         head_r = head_q + n_ret[CP_IDX_W-1:0];
         size_r = size_q - n_ret;
      end
   end

   // Recover target must still be live after this cycle's retires.
   always_comb begin
      rec_dist = cp_if.recover_idx - head_r;
      rec_live = (size_r != '0) && ({1'b0, rec_dist} < size_r);
   end

   // Allocation: indices are combinational and valid whether or not the group fires.
   always_comb begin
      n_req = '0;
      for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
         n_req = n_req + SUM_W'(cp_if.alloc_req[i]);
      end
      size_sum = {1'b0, size_r} + n_req;
      ready    = (state_q == RUN) && !cp_if.recover && (size_sum <= SUM_W'(CP_SIZE));
      fire     = ready && !cp_if.stall && (n_req != '0);

      alloc_base = head_r + size_r[CP_IDX_W-1:0];
      alloc_off  = '0;
      idx_vec    = '0;
      for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
         idx_vec[i*CP_IDX_W +: CP_IDX_W] = alloc_base + alloc_off;
         if (cp_if.alloc_req[i]) begin
            alloc_off = alloc_off + CP_IDX_W'(1);
         end
      end
   end

   // Next-state: restore countdown, then recover overrides, then allocation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      head_d  = head_r;
      size_d  = size_r;
      err_d   = err_q | ret_err;

      if (state_q == RESTORE) begin
         if (cnt_q == '0) begin
            state_d = RUN;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      if (cp_if.recover) begin
         if (rec_live) begin
            size_d  = {1'b0, rec_dist} + SZ_W'(1);
            state_d = RESTORE;
            cnt_d   = CNT_W'(RESTORE_CYC - 1);
         end else begin
            err_d = 1'b1;
         end
      end else if (fire) begin
         size_d = SZ_W'(size_sum);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         head_q  <= '0;
         size_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         size_q  <= size_d;
         err_q   <= err_d;
      end
   end

   assign cp_if.alloc_ready = ready;
   assign cp_if.alloc_idx   = idx_vec;
   assign cp_if.check       = fire;
   assign cp_if.check_flag  = fire ? cp_if.alloc_req : '0;
   assign cp_if.recovering  = (state_q == RESTORE);
   assign cp_head           = head_q;
   assign cp_size           = size_q;
   assign err               = err_q;

endmodule

// File: tb/tb_br_checkpoint_ctrl.sv
// Directed bench for br_checkpoint_ctrl: fill, full-with-retire, recover window,
// recover to a just-retired slot, stall, and asynchronous reset mid-restore.
module tb_br_checkpoint_ctrl;

   logic       clock;
   logic       reset;
   logic [2:0] cp_head;
   logic [3:0] cp_size;
   logic       err;
   int         total;
   int         bad;

   br_checkpoint_ctrl_if #(.CP_IDX_W(3), .RENAME_WIDTH(2), .COMMIT_WIDTH(2)) cp_if ();

   br_checkpoint_ctrl #(
      .CP_SIZE(8), .CP_IDX_W(3), .RENAME_WIDTH(2), .COMMIT_WIDTH(2), .RESTORE_CYC(2)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .cp_if   (cp_if),
      .cp_head (cp_head),
      .cp_size (cp_size),
      .err     (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic drive(input logic st, input logic [1:0] req, input logic [1:0] ret,
                        input logic rec, input logic [2:0] ridx);
      cp_if.stall       = st;
      cp_if.alloc_req   = req;
      cp_if.retire_br   = ret;
      cp_if.recover     = rec;
      cp_if.recover_idx = ridx;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      reset = 1'b0;
      #3;
      total++; if (cp_size !== 4'd0) begin bad++; $display("FAIL rst_size got=%0d exp=0", cp_size); end
      total++; if (cp_head !== 3'd0) begin bad++; $display("FAIL rst_head got=%0d exp=0", cp_head); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      total++; if ({cp_if.alloc_ready, cp_if.check, cp_if.check_flag, cp_if.recovering} !== 5'b10000)
         begin bad++; $display("FAIL rst_outs got=%b exp=10000", {cp_if.alloc_ready, cp_if.check, cp_if.check_flag, cp_if.recovering}); end
      tick();
      reset = 1'b1;
   endtask

   task automatic test_fill();
      logic [5:0] exp_idx;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 2'b11, 2'b00, 1'b0, 3'd0);
         #1;
         exp_idx = {3'(2*k+1), 3'(2*k)};
         total++; if (cp_if.alloc_idx !== exp_idx || cp_if.alloc_ready !== 1'b1 || cp_if.check !== 1'b1 || cp_if.check_flag !== 2'b11)
            begin bad++; $display("FAIL fill_grant%0d got idx=%h rdy=%b chk=%b flg=%b exp idx=%h 1 1 11", k, cp_if.alloc_idx, cp_if.alloc_ready, cp_if.check, cp_if.check_flag, exp_idx); end
         tick();
      end
      drive(1'b0, 2'b11, 2'b00, 1'b0, 3'd0);
      #1;
      total++; if (cp_if.alloc_ready !== 1'b0 || cp_if.check !== 1'b0)
         begin bad++; $display("FAIL fill_full got rdy=%b chk=%b exp 0 0", cp_if.alloc_ready, cp_if.check); end
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      total++; if (cp_size !== 4'd8 || cp_head !== 3'd0)
         begin bad++; $display("FAIL fill_size got size=%0d head=%0d exp 8 0", cp_size, cp_head); end
   endtask

   task automatic test_full_retire();
      drive(1'b0, 2'b01, 2'b01, 1'b0, 3'd0);
      #1;
      total++; if (cp_if.alloc_ready !== 1'b1 || cp_if.alloc_idx[2:0] !== 3'd0 || cp_if.check !== 1'b1)
         begin bad++; $display("FAIL full_ret_grant got rdy=%b idx=%0d chk=%b exp 1 0 1", cp_if.alloc_ready, cp_if.alloc_idx[2:0], cp_if.check); end
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      total++; if (cp_size !== 4'd8 || cp_head !== 3'd1)
         begin bad++; $display("FAIL full_ret_state got size=%0d head=%0d exp 8 1", cp_size, cp_head); end
   endtask

   task automatic test_recover_window();
      drive(1'b0, 2'b00, 2'b11, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b00, 2'b11, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b00, 2'b01, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b01, 2'b00, 1'b0, 3'd0);
      #1;
      total++; if (cp_if.alloc_idx[2:0] !== 3'd1 || cp_if.check !== 1'b1)
         begin bad++; $display("FAIL wrap_idx got idx=%0d chk=%b exp 1 1", cp_if.alloc_idx[2:0], cp_if.check); end
      tick();
      total++; if (cp_size !== 4'd4 || cp_head !== 3'd6)
         begin bad++; $display("FAIL rec_setup got size=%0d head=%0d exp 4 6", cp_size, cp_head); end
      drive(1'b0, 2'b01, 2'b00, 1'b1, 3'd7);
      #1;
      total++; if (cp_if.alloc_ready !== 1'b0 || cp_if.check !== 1'b0)
         begin bad++; $display("FAIL rec_block got rdy=%b chk=%b exp 0 0", cp_if.alloc_ready, cp_if.check); end
      tick();
      drive(1'b0, 2'b01, 2'b00, 1'b0, 3'd0);
      #1;
      total++; if (cp_size !== 4'd2 || cp_head !== 3'd6 || cp_if.recovering !== 1'b1 || cp_if.alloc_ready !== 1'b0 || cp_if.check !== 1'b0)
         begin bad++; $display("FAIL rec_win1 got size=%0d head=%0d recv=%b rdy=%b chk=%b exp 2 6 1 0 0", cp_size, cp_head, cp_if.recovering, cp_if.alloc_ready, cp_if.check); end
      tick();
      #1;
      total++; if (cp_if.recovering !== 1'b1 || cp_if.alloc_ready !== 1'b0)
         begin bad++; $display("FAIL rec_win2 got recv=%b rdy=%b exp 1 0", cp_if.recovering, cp_if.alloc_ready); end
      tick();
      #1;
      total++; if (cp_if.recovering !== 1'b0 || cp_if.alloc_ready !== 1'b1 || cp_size !== 4'd2)
         begin bad++; $display("FAIL rec_done got recv=%b rdy=%b size=%0d exp 0 1 2", cp_if.recovering, cp_if.alloc_ready, cp_size); end
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
   endtask

   task automatic test_recover_retired();
      apply_reset();
      drive(1'b0, 2'b11, 2'b00, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b01, 2'b00, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b00, 2'b11, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b11, 2'b00, 1'b0, 3'd0); tick();
      total++; if (cp_size !== 4'd3 || cp_head !== 3'd2 || err !== 1'b0)
         begin bad++; $display("FAIL retrec_setup got size=%0d head=%0d err=%b exp 3 2 0", cp_size, cp_head, err); end
      drive(1'b0, 2'b00, 2'b01, 1'b1, 3'd2);
      #1;
      total++; if (cp_if.alloc_ready !== 1'b0)
         begin bad++; $display("FAIL retrec_block got rdy=%b exp 0", cp_if.alloc_ready); end
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      #1;
      total++; if (err !== 1'b1 || cp_size !== 4'd2 || cp_head !== 3'd3 || cp_if.recovering !== 1'b0 || cp_if.alloc_ready !== 1'b1)
         begin bad++; $display("FAIL retrec_state got err=%b size=%0d head=%0d recv=%b rdy=%b exp 1 2 3 0 1", err, cp_size, cp_head, cp_if.recovering, cp_if.alloc_ready); end
   endtask

   task automatic test_stall();
      drive(1'b1, 2'b10, 2'b00, 1'b0, 3'd0);
      #1;
      total++; if (cp_if.alloc_ready !== 1'b1 || cp_if.check !== 1'b0 || cp_if.check_flag !== 2'b00)
         begin bad++; $display("FAIL stall_hold got rdy=%b chk=%b flg=%b exp 1 0 00", cp_if.alloc_ready, cp_if.check, cp_if.check_flag); end
      tick();
      total++; if (cp_size !== 4'd2)
         begin bad++; $display("FAIL stall_size got=%0d exp=2", cp_size); end
      drive(1'b0, 2'b10, 2'b00, 1'b0, 3'd0);
      #1;
      total++; if (cp_if.alloc_idx[5:3] !== 3'd5 || cp_if.check !== 1'b1 || cp_if.check_flag !== 2'b10)
         begin bad++; $display("FAIL stall_release got idx1=%0d chk=%b flg=%b exp 5 1 10", cp_if.alloc_idx[5:3], cp_if.check, cp_if.check_flag); end
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      total++; if (cp_size !== 4'd3)
         begin bad++; $display("FAIL stall_after got=%0d exp=3", cp_size); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive(1'b0, 2'b00, 2'b01, 1'b0, 3'd0); tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      total++; if (err !== 1'b1 || cp_size !== 4'd0 || cp_head !== 3'd0)
         begin bad++; $display("FAIL empty_ret got err=%b size=%0d head=%0d exp 1 0 0", err, cp_size, cp_head); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 2'b11, 2'b00, 1'b0, 3'd0); tick();
      end
      drive(1'b0, 2'b00, 2'b00, 1'b1, 3'd4); tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      total++; if (cp_size !== 4'd5 || cp_if.recovering !== 1'b1)
         begin bad++; $display("FAIL arst_setup got size=%0d recv=%b exp 5 1", cp_size, cp_if.recovering); end
      #1;
      reset = 1'b0;
      #1;
      total++; if (cp_size !== 4'd0 || cp_if.recovering !== 1'b0 || err !== 1'b0 || cp_head !== 3'd0 || cp_if.alloc_ready !== 1'b1)
         begin bad++; $display("FAIL arst_clear got size=%0d recv=%b err=%b head=%0d rdy=%b exp 0 0 0 0 1", cp_size, cp_if.recovering, err, cp_head, cp_if.alloc_ready); end
      tick();
      reset = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      drive(1'b0, 2'b00, 2'b00, 1'b0, 3'd0);
      test_reset();
      test_fill();
      test_full_retire();
      test_recover_window();
      test_recover_retired();
      test_stall();
      test_async_reset();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
